// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and widths for the APB master arbiter slice.
// The optional bus-lock feature is selected by APB_ARB_LOCK_EN.
package apb_arb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } arb_state_t;

    // Owner index width; a 2-requester build still needs one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester/bridge bundle for apb_master_arbiter; req_lock exists only
// when APB_ARB_LOCK_EN is defined.
interface apb_master_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2
) ();

    // Handshake: a requester raises req with stable payload and holds it until
    // its one-cycle done pulse; rsp_* are valid only while done is non-zero.
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*APB_AW-1:0] req_addr;
    logic [NREQ*APB_DW-1:0] req_wdata;
`ifdef APB_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic [NREQ-1:0]        done;
    logic [APB_DW-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [NREQ-1:0]        gnt;
    logic                   transfer;
    logic                   write_read;
    logic [APB_AW-1:0]      addr;
    logic [APB_DW-1:0]      wdata;
    logic [APB_DW-1:0]      rdata;
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PREADY;
    logic                   PSLVERR;

`ifdef APB_ARB_LOCK_EN
    modport master (
        input  req, req_write, req_addr, req_wdata, req_lock,
        input  rdata, PSEL, PENABLE, PREADY, PSLVERR,
        output done, rsp_rdata, rsp_err, gnt,
        output transfer, write_read, addr, wdata
    );
    modport slave (
        output req, req_write, req_addr, req_wdata, req_lock,
        output rdata, PSEL, PENABLE, PREADY, PSLVERR,
        input  done, rsp_rdata, rsp_err, gnt,
        input  transfer, write_read, addr, wdata
    );
`else
    modport master (
        input  req, req_write, req_addr, req_wdata,
        input  rdata, PSEL, PENABLE, PREADY, PSLVERR,
        output done, rsp_rdata, rsp_err, gnt,
        output transfer, write_read, addr, wdata
    );
    modport slave (
        output req, req_write, req_addr, req_wdata,
        output rdata, PSEL, PENABLE, PREADY, PSLVERR,
        input  done, rsp_rdata, rsp_err, gnt,
        input  transfer, write_read, addr, wdata
    );
`endif

endinterface

// File: rtl/apb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from (last owner + 1) mod NREQ.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int OW   = owner_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_last,
    output logic            o_valid,
    output logic [OW-1:0]   o_idx
);

    logic [OW-1:0] w_pos;

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_pos = OW'((int'(i_last) + k) % NREQ);
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter/sequencer sharing the APB bridge command port among NREQ
// requesters. Define APB_ARB_LOCK_EN to let a locked owner chain transfers.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    apb_master_arbiter_if.master bus,
    output arb_state_t           o_dbg_state
);

    localparam int OW = owner_w(NREQ);

    arb_state_t        r_state;
    logic [OW-1:0]     r_last;
    logic [OW-1:0]     r_owner;
    logic              r_transfer;
    logic              r_write;
    logic [APB_AW-1:0] r_addr;
    logic [APB_DW-1:0] r_wdata;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic [APB_DW-1:0] r_rdata;
    logic              r_err;

    logic              w_valid;
    logic [OW-1:0]     w_pick;
    logic [OW-1:0]     w_sel;
    logic              w_sel_write;
    logic [APB_AW-1:0] w_sel_addr;
    logic [APB_DW-1:0] w_sel_wdata;
    logic              w_apb_done;

    apb_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );

    // Payload source: the new winner from IDLE, the current owner on a locked re-issue.
    assign w_sel       = (r_state == IDLE) ? w_pick : r_owner;
    assign w_sel_write = bus.req_write[w_sel];
    assign w_sel_addr  = bus.req_addr[w_sel*APB_AW +: APB_AW];
    assign w_sel_wdata = bus.req_wdata[w_sel*APB_DW +: APB_DW];
    assign w_apb_done  = bus.PSEL & bus.PENABLE & bus.PREADY;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_last     <= OW'(NREQ - 1);
            r_owner    <= '0;
            r_transfer <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_transfer <= 1'b0;
            r_done     <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner    <= w_pick;
                        r_last     <= w_pick;
                        r_gnt      <= NREQ'(1) << w_pick;
                        r_write    <= w_sel_write;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_transfer <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_apb_done) begin
                        r_rdata <= r_write ? '0 : bus.rdata;
                        r_err   <= bus.PSLVERR;
                        r_done  <= r_gnt;
                        r_state <= COMPLETE;
                    end
                end
                COMPLETE: begin
`ifdef APB_ARB_LOCK_EN
                    if (bus.req_lock[r_owner] && bus.req[r_owner]) begin
                        r_write    <= w_sel_write;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_transfer <= 1'b1;
                        r_state    <= ISSUE;
                    end else begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
`else
                    r_gnt   <= '0;
                    r_state <= IDLE;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.done       = r_done;
    assign bus.rsp_rdata  = r_rdata;
    assign bus.rsp_err    = r_err;
    assign bus.gnt        = r_gnt;
    assign bus.transfer   = r_transfer;
    assign bus.write_read = r_write;
    assign bus.addr       = r_addr;
    assign bus.wdata      = r_wdata;
    assign o_dbg_state    = r_state;

endmodule
